// File: rtl/mic1_pkg.sv
// Shared types and constants for the MIC-1 memory sequencer and datapath.
package mic1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_e;

  // Bit positions of the memory strobes inside the MIR memory field.
  localparam int unsigned MIR_WRITE = 2;
  localparam int unsigned MIR_READ  = 1;
  localparam int unsigned MIR_FETCH = 0;

  localparam int unsigned BYTE_LANES = 4;

endpackage

// File: rtl/mic1_byte_sel.sv
// Big-endian byte lane select: lane 0 is the most significant byte of the word.
module mic1_byte_sel
  import mic1_pkg::*;
(
  input  logic [8*BYTE_LANES-1:0] word,
  input  logic [1:0]              lane,
  output logic [7:0]              byte_out
);

  always_comb begin
    byte_out = '0;
    for (int unsigned i = 0; i < BYTE_LANES; i++) begin
      if (lane == 2'(i)) byte_out = word[8*(BYTE_LANES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory sequencer: captures READ/WRITE/FETCH strobes and arbitrates the
// data (MAR/MDR) and fetch (PC/MBR) ports onto one valid/ready memory bus.
module mic1_mem_ctrl
  import mic1_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic          fetch_req,
  input  logic [AW-1:0] mar,
  input  logic [DW-1:0] mdr_q,
  input  logic [AW-1:0] pc,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mdr_load,
  output logic [DW-1:0] mdr_in,
  output logic          mbr_load,
  output logic [7:0]    mbr_in,
  output logic          stall,
  output logic          err
);

  state_e        state, state_nxt;
  logic          pend_data, pend_fetch;
  logic          pend_data_nxt, pend_fetch_nxt;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [AW-1:0] fetch_pc;
  logic          busy, data_done, fetch_done;
  logic          cap_data, cap_fetch;
  logic [7:0]    lane_byte;

  mic1_byte_sel u_byte_sel (
    .word     (mem_rdata[8*BYTE_LANES-1:0]),
    .lane     (fetch_pc[1:0]),
    .byte_out (lane_byte)
  );

  always_comb begin
    busy       = (state != IDLE);
    data_done  = (state == DATA)  & mem_ready;
    fetch_done = (state == FETCH) & mem_ready;
    stall      = (pend_data | pend_fetch) &
                 !((data_done & !pend_fetch) | (fetch_done & !pend_data));
    cap_data   = !stall & (rd_req | wr_req);
    cap_fetch  = !stall & fetch_req;

    pend_data_nxt  = (pend_data  & !data_done)  | cap_data;
    pend_fetch_nxt = (pend_fetch & !fetch_done) | cap_fetch;

    // The state always mirrors the highest-priority pending bit once the bus
    // is free, so a capture at edge t puts the request on the bus in cycle t+1.
    state_nxt = state;
    if (!busy || mem_ready) begin
      if (pend_data_nxt)       state_nxt = DATA;
      else if (pend_fetch_nxt) state_nxt = FETCH;
      else                     state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pend_data  <= 1'b0;
      pend_fetch <= 1'b0;
      data_we    <= 1'b0;
      data_addr  <= '0;
      data_wdata <= '0;
      fetch_pc   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_data  <= pend_data_nxt;
      pend_fetch <= pend_fetch_nxt;
      if (cap_data) begin
        data_we    <= wr_req;
        data_addr  <= mar << 2;
        data_wdata <= mdr_q;
        if (rd_req && wr_req) err <= 1'b1;
      end
      if (cap_fetch) fetch_pc <= pc;
    end
  end

  always_comb begin
    mem_valid = busy;
    mem_addr  = '0;
    if (state == DATA)       mem_addr = data_addr;
    else if (state == FETCH) mem_addr = {fetch_pc[AW-1:2], 2'b00};
    mem_we    = (state == DATA) & data_we;
    mem_wdata = mem_we ? data_wdata : '0;
    mdr_load  = data_done & !data_we;
    mdr_in    = mdr_load ? mem_rdata : '0;
    mbr_load  = fetch_done;
    mbr_in    = mbr_load ? lane_byte : '0;
  end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Scoreboard bench for mic1_mem_ctrl: expected bus transactions are queued when
// strobes are driven and retired by a monitor on each completed transfer.
module tb_mic1_mem_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            kind;   // 0 = write, 1 = MDR load, 2 = MBR load
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_req = 1'b0, wr_req = 1'b0, fetch_req = 1'b0;
  logic [AW-1:0] mar = '0, pc = '0;
  logic [DW-1:0] mdr_q = '0, mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          mem_valid, mem_we, mdr_load, mbr_load, stall, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mdr_in;
  logic [7:0]    mbr_in;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mic1_mem_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar(mar), .mdr_q(mdr_q), .pc(pc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mdr_load(mdr_load), .mdr_in(mdr_in),
    .mbr_load(mbr_load), .mbr_in(mbr_in),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_data(input logic we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.we = we; e.addr = a * 4; e.wdata = wd; e.kind = we ? 0 : 1; e.data = rd;
    return e;
  endfunction

  function automatic exp_t exp_fetch(input logic [AW-1:0] p, input logic [DW-1:0] rd);
    exp_t e;
    e.we = 1'b0; e.addr = p & ~32'h3; e.wdata = '0; e.kind = 2;
    e.data = (rd >> (24 - 8 * int'(p % 4))) & 32'hFF;
    return e;
  endfunction

  // Monitor: retire one scoreboard entry per completed bus transfer.
  always @(negedge clk) begin
    if (rst && mem_valid && mem_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_txn: addr=%h we=%b, none expected", mem_addr, mem_we);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_we !== e.we) begin
          errors++;
          $display("FAIL txn_addr: addr=%h we=%b, expected addr=%h we=%b",
                   mem_addr, mem_we, e.addr, e.we);
        end
        if (e.we && mem_wdata !== e.wdata) begin
          errors++;
          $display("FAIL txn_wdata: got %h, expected %h", mem_wdata, e.wdata);
        end
        if (mdr_load !== (e.kind == 1) || mbr_load !== (e.kind == 2)) begin
          errors++;
          $display("FAIL txn_load: mdr_load=%b mbr_load=%b, expected kind %0d",
                   mdr_load, mbr_load, e.kind);
        end
        if (e.kind == 1 && mdr_in !== e.data) begin
          errors++;
          $display("FAIL txn_mdr_in: got %h, expected %h", mdr_in, e.data);
        end
        if (e.kind == 2 && {24'h0, mbr_in} !== e.data) begin
          errors++;
          $display("FAIL txn_mbr_in: got %h, expected %h", mbr_in, e.data[7:0]);
        end
      end
    end else if (mdr_load !== 1'b0 || mbr_load !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL stray_load: mdr_load=%b mbr_load=%b, expected 0 0", mdr_load, mbr_load);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_valid, stall, err, mdr_load, mbr_load, mem_we} !== 6'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b stall=%b err=%b addr=%h, expected all 0",
               mem_valid, stall, err, mem_addr);
    end
    repeat (2) next_cycle();
    rst = 1'b1;
    next_cycle();
    wr_req = 1'b1; mar = 32'h3; mdr_q = 32'h55; mem_ready = 1'b0;
    sb.push_back(exp_data(1'b1, mar, mdr_q, '0));
    next_cycle();
    clear_strobes();
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_valid: mem_valid=%b, expected 1", mem_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midtxn: valid=%b stall=%b err=%b, expected 0 0 0",
               mem_valid, stall, err);
    end
    sb.delete();
    next_cycle();
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (mem_valid !== 1'b0 || mdr_load !== 1'b0 || mbr_load !== 1'b0) begin
        errors++;
        $display("FAIL reset_residual: valid=%b mdr_load=%b mbr_load=%b, expected 0",
                 mem_valid, mdr_load, mbr_load);
      end
    end
  endtask

  task automatic test_read();
    next_cycle();
    rd_req = 1'b1; mar = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    sb.push_back(exp_data(1'b0, mar, '0, mem_rdata));
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL read_stall_t: stall=%b, expected 0", stall);
    end
    next_cycle();
    clear_strobes();
    #1;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mdr_load !== 1'b1 ||
        mdr_in !== 32'hDEADBEEF || stall !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: valid=%b addr=%h mdr_load=%b mdr_in=%h stall=%b, expected 1 40 1 deadbeef 0",
               mem_valid, mem_addr, mdr_load, mdr_in, stall);
    end
    next_cycle();
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_done: mem_valid=%b, expected 0", mem_valid);
    end
  endtask

  task automatic test_fetch();
    logic [AW-1:0] pcs [3]  = '{32'h103, 32'h100, 32'h101};
    logic [7:0]    exps [3] = '{8'h44, 8'h11, 8'h22};
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      fetch_req = 1'b1; pc = pcs[i]; mem_ready = 1'b1; mem_rdata = 32'h11223344;
      sb.push_back(exp_fetch(pc, mem_rdata));
      next_cycle();
      clear_strobes();
      #1;
      checks++;
      if (mem_addr !== (pcs[i] & ~32'h3) || mbr_load !== 1'b1 || mbr_in !== exps[i] || stall !== 1'b0) begin
        errors++;
        $display("FAIL fetch_%0d: addr=%h mbr_load=%b mbr_in=%h stall=%b, expected %h 1 %h 0",
                 i, mem_addr, mbr_load, mbr_in, stall, pcs[i] & ~32'h3, exps[i]);
      end
    end
  endtask

  task automatic test_write_wait();
    next_cycle();
    wr_req = 1'b1; mar = 32'h2; mdr_q = 32'hCAFE; mem_ready = 1'b0;
    sb.push_back(exp_data(1'b1, mar, mdr_q, '0));
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      clear_strobes();
      if (c == 4) mem_ready = 1'b1;
      #1;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h8 || mem_we !== 1'b1 ||
          mem_wdata !== 32'hCAFE || mdr_load !== 1'b0 || stall !== (c != 4)) begin
        errors++;
        $display("FAIL write_wait_c%0d: valid=%b addr=%h we=%b wdata=%h mdr_load=%b stall=%b, expected 1 8 1 cafe 0 %b",
                 c, mem_valid, mem_addr, mem_we, mem_wdata, mdr_load, stall, c != 4);
      end
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    rd_req = 1'b1; fetch_req = 1'b1; mar = 32'h20; pc = 32'h202;
    mem_ready = 1'b1; mem_rdata = 32'hA1B2C3D4;
    sb.push_back(exp_data(1'b0, mar, '0, mem_rdata));
    sb.push_back(exp_fetch(pc, mem_rdata));
    next_cycle();
    // Strobes presented while stalled must be ignored.
    rd_req = 1'b0; fetch_req = 1'b0; wr_req = 1'b1; mar = 32'h3F;
    #1;
    checks++;
    if (stall !== 1'b1 || mdr_load !== 1'b1 || mbr_load !== 1'b0 || mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL b2b_data: stall=%b mdr_load=%b mbr_load=%b addr=%h, expected 1 1 0 80",
               stall, mdr_load, mbr_load, mem_addr);
    end
    next_cycle();
    clear_strobes();
    #1;
    checks++;
    if (stall !== 1'b0 || mbr_load !== 1'b1 || mbr_in !== 8'hC3 || mdr_load !== 1'b0 ||
        mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL b2b_fetch: stall=%b mbr_load=%b mbr_in=%h mdr_load=%b addr=%h, expected 0 1 c3 0 200",
               stall, mbr_load, mbr_in, mdr_load, mem_addr);
    end
    next_cycle();
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: mem_valid=%b, expected 0", mem_valid);
    end
  endtask

  task automatic test_rd_wr_conflict();
    next_cycle();
    rd_req = 1'b1; wr_req = 1'b1; mar = 32'h5; mdr_q = 32'h1234; mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    sb.push_back(exp_data(1'b1, mar, mdr_q, '0));
    next_cycle();
    clear_strobes();
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h14 || mdr_load !== 1'b0) begin
      errors++;
      $display("FAIL conflict_write: we=%b addr=%h mdr_load=%b, expected 1 14 0",
               mem_we, mem_addr, mdr_load);
    end
    repeat (3) next_cycle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL conflict_err_sticky: err=%b, expected 1", err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL conflict_err_reset: err=%b, expected 0", err);
    end
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_fetch();
    test_write_wait();
    test_back_to_back();
    test_rd_wr_conflict();
    repeat (2) next_cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transactions never completed, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic1_mem_ctrl.md
Name: mic1_mem_ctrl

Overview:
- Memory sequencer and arbiter for the MIC-1 datapath.
- Captures the READ, WRITE and FETCH strobes decoded from MIR and arbitrates the data port (MAR/MDR, word) and the fetch port (PC/MBR, byte) onto one shared valid/ready memory bus.
- Returns load pulses and data for MDR/MBR.
- Raises a stall to the controlpath whenever memory cannot honour the MIC-1 one-cycle-delay rule.

Parameters:
- AW, 32, width of MAR/PC and of the memory byte address.
- DW, 32, memory data width (fixed at 32 for MIC-1; parameterised only for the bench).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_req  in  1  MIR READ bit, sampled when stall=0.
- wr_req  in  1  MIR WRITE bit, sampled when stall=0.
- fetch_req  in  1  MIR FETCH bit, sampled when stall=0.
- mar  in  AW  word address for data ops.
- mdr_q  in  DW  current MDR contents, used as write data.
- pc  in  AW  byte address for fetch.
- mem_valid  out  1  request valid.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- mem_addr  out  AW  byte address.
- mem_we  out  1  1 = write.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid when mem_valid & mem_ready & !mem_we.
- mdr_load  out  1  one-cycle pulse: load MDR from mdr_in.
- mdr_in  out  DW  read word for MDR.
- mbr_load  out  1  one-cycle pulse: load MBR from mbr_in.
- mbr_in  out  8  fetched byte for MBR.
- stall  out  1  controlpath must hold MPC/MIR this cycle.
- err  out  1  sticky: rd_req and wr_req seen together.

Behaviour:
- Reset (rst=0, async): state IDLE, pending bits cleared, all outputs 0. mem_valid drops in the same cycle even mid-transaction.
- Capture on a rising edge with stall=0:
  - rd_req/wr_req set pend_data, latching op, mar<<2 (word to byte address) and mdr_q.
  - fetch_req sets pend_fetch, latching pc.
  - rd_req & wr_req together: write wins, err set (cleared only by reset).
- Arbitration: one transaction outstanding at a time. Data has priority over fetch. A pending fetch issues in the cycle after data completes. No starvation, since each port holds at most one request.
- States:
  - IDLE -> DATA if pend_data, else FETCH if pend_fetch.
  - DATA -> FETCH on completion if pend_fetch, else IDLE.
  - FETCH -> IDLE on completion. A fetch never preempts pending data because new captures occur only while stall=0.
- Issue: a request captured at edge t drives mem_valid=1 during cycle t+1, with mem_addr/mem_we/mem_wdata from the latches. These hold stable until mem_ready=1.
- Fetch address: {pc[AW-1:2],2'b00}. Byte select is big-endian: mbr_in = mem_rdata[8*(3-pc[1:0]) +: 8] using the latched pc.
- Completion (mem_valid & mem_ready):
  - Read: mdr_load=1, mdr_in=mem_rdata, same cycle.
  - Fetch: mbr_load=1.
  - Write: no load.
  - The pending bit clears at the edge.
- Latency: with mem_ready tied high, MDR/MBR are written at the end of cycle t+1, matching MIC-1 semantics; no stall occurs.
- Stall (combinational): stall = (pend_data|pend_fetch) & !(completing_now & no other pending bit). While stall=1, all strobes are ignored; the controlpath re-presents MIR.
- READ+FETCH in the same microinstruction: data completes first, then fetch. Stall is high for at least one cycle.
- mem_ready high while mem_valid is low: ignored.

Decomposition:
- Shared package mic1_pkg:
  - state enum {IDLE, DATA, FETCH}.
  - MIR memory-bit index constants (WRITE, READ, FETCH).
  - BYTE_LANES=4.
- Sub-module mic1_byte_sel: combinational 32->8 big-endian lane select, reused by the datapath.

Test Plan:
- Reset mid-transaction: rst low while mem_valid=1 -> mem_valid=0 immediately, stall=0, err=0. After release, no residual load.
- rd_req, mar=0x10, mem_ready=1, mem_rdata=0xDEADBEEF -> next cycle mem_addr=0x40, mdr_load=1, mdr_in=0xDEADBEEF, stall=0 throughout.
- fetch_req, pc=0x103, rdata=0x11223344 -> mem_addr=0x100, mbr_load=1, mbr_in=0x44. Repeat with pc=0x100 -> 0x11.
- wr_req, mar=0x2, mdr_q=0xCAFE, mem_ready low 3 cycles -> mem_addr=0x8, mem_we=1, wdata=0xCAFE stable for 4 cycles. stall=1 for cycles 1-3, then 0. No mdr_load.
- rd_req+fetch_req together, ready=1 -> data read in cycle t+1 (stall=1), fetch in t+2 (stall=0). mdr_load precedes mbr_load. New strobes in t+1 are ignored.
- rd_req+wr_req together -> write issued, no read, err=1 held until reset.
